// File: rtl/boot_sequencer.sv
// Boot/run controller for the single-cycle MIPS core: streams the instruction and
// data images into memory, captures PC/$sp, releases the core and halts it on budget.
module boot_sequencer #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  parameter int unsigned RUN_CYCLES = 100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_data_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_data_o,
  output logic [31:0] pc_init_o,
  output logic        pc_load_o,
  output logic [31:0] sp_init_o,
  output logic        sp_load_o,
  output logic        cpu_rst_n_o,
  output logic        cpu_clk_en_o,
  output logic [31:0] cycle_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned W = 32;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_I_PC    = 4'd1;
  localparam logic [3:0] S_I_CNT   = 4'd2;
  localparam logic [3:0] S_I_BODY  = 4'd3;
  localparam logic [3:0] S_D_SP    = 4'd4;
  localparam logic [3:0] S_D_CNT   = 4'd5;
  localparam logic [3:0] S_D_BODY  = 4'd6;
  localparam logic [3:0] S_RELEASE = 4'd7;
  localparam logic [3:0] S_RUN     = 4'd8;
  localparam logic [3:0] S_HALT    = 4'd9;
  localparam logic [3:0] S_ERR     = 4'd10;

  logic [3:0]   r_state, w_state_nxt;
  logic [W-1:0] r_cnt, w_cnt_nxt;
  logic [W-1:0] r_idx, w_idx_nxt;
  logic [W-1:0] r_pc, w_pc_nxt;
  logic [W-1:0] r_sp, w_sp_nxt;
  logic [W-1:0] r_cycle, w_cycle_nxt;
  logic         r_im_we, w_im_we_nxt;
  logic [W-1:0] r_im_addr, w_im_addr_nxt;
  logic [W-1:0] r_im_data, w_im_data_nxt;
  logic         r_dm_we, w_dm_we_nxt;
  logic [W-1:0] r_dm_addr, w_dm_addr_nxt;
  logic [W-1:0] r_dm_data, w_dm_data_nxt;
  logic         r_ready, w_ready_nxt;
  logic         r_pc_load, w_pc_load_nxt;
  logic         r_sp_load, w_sp_load_nxt;
  logic         r_rst_n, w_rst_n_nxt;
  logic         r_clk_en, w_clk_en_nxt;
  logic         r_done, w_done_nxt;
  logic         r_err, w_err_nxt;
  logic         w_xfer;

  assign w_xfer = in_valid_i & r_ready;

  // Next-state, datapath updates and state-decoded outputs (registered below)
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_pc_nxt      = r_pc;
    w_sp_nxt      = r_sp;
    w_cycle_nxt   = r_cycle;
    w_im_we_nxt   = 1'b0;
    w_im_addr_nxt = r_im_addr;
    w_im_data_nxt = r_im_data;
    w_dm_we_nxt   = 1'b0;
    w_dm_addr_nxt = r_dm_addr;
    w_dm_data_nxt = r_dm_data;
    case (r_state)
      S_IDLE: if (start_i) w_state_nxt = S_I_PC;
      S_I_PC: if (w_xfer) begin
        w_pc_nxt    = in_data_i;
        w_state_nxt = S_I_CNT;
      end
      S_I_CNT: if (w_xfer) begin
        w_cnt_nxt = in_data_i;
        w_idx_nxt = '0;
        if (in_data_i > W'(IMEM_WORDS))  w_state_nxt = S_ERR;
        else if (in_data_i == '0)        w_state_nxt = S_D_SP;
        else                             w_state_nxt = S_I_BODY;
      end
      S_I_BODY: if (w_xfer) begin
        w_im_we_nxt   = 1'b1;
        w_im_addr_nxt = r_idx;
        w_im_data_nxt = in_data_i;
        w_idx_nxt     = r_idx + W'(1);
        if (r_idx + W'(1) == r_cnt) w_state_nxt = S_D_SP;
      end
      S_D_SP: if (w_xfer) begin
        w_sp_nxt    = in_data_i;
        w_state_nxt = S_D_CNT;
      end
      S_D_CNT: if (w_xfer) begin
        w_cnt_nxt = in_data_i;
        w_idx_nxt = '0;
        if (in_data_i > W'(DMEM_WORDS))  w_state_nxt = S_ERR;
        else if (in_data_i == '0)        w_state_nxt = S_RELEASE;
        else                             w_state_nxt = S_D_BODY;
      end
      S_D_BODY: if (w_xfer) begin
        w_dm_we_nxt   = 1'b1;
        w_dm_addr_nxt = r_idx << 2;
        w_dm_data_nxt = in_data_i;
        w_idx_nxt     = r_idx + W'(1);
        if (r_idx + W'(1) == r_cnt) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: w_state_nxt = S_RUN;
      S_RUN: begin
        // Saturates only matters when there is no budget to stop at
        if (r_cycle != '1) w_cycle_nxt = r_cycle + W'(1);
        if ((RUN_CYCLES != 0) && (r_cycle + W'(1) == W'(RUN_CYCLES))) w_state_nxt = S_HALT;
      end
      S_HALT: if (start_i) begin
        w_state_nxt = S_I_PC;
        w_cycle_nxt = '0;
      end
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase

    w_ready_nxt   = (w_state_nxt == S_I_PC) || (w_state_nxt == S_I_CNT) ||
                    (w_state_nxt == S_I_BODY) || (w_state_nxt == S_D_SP) ||
                    (w_state_nxt == S_D_CNT) || (w_state_nxt == S_D_BODY);
    w_pc_load_nxt = (w_state_nxt == S_RELEASE);
    w_sp_load_nxt = (w_state_nxt == S_RELEASE);
    w_rst_n_nxt   = (w_state_nxt == S_RUN) || (w_state_nxt == S_HALT);
    w_clk_en_nxt  = (w_state_nxt == S_RUN);
    w_done_nxt    = (w_state_nxt == S_HALT);
    w_err_nxt     = (w_state_nxt == S_ERR);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_pc      <= '0;
      r_sp      <= '0;
      r_cycle   <= '0;
      r_im_we   <= 1'b0;
      r_im_addr <= '0;
      r_im_data <= '0;
      r_dm_we   <= 1'b0;
      r_dm_addr <= '0;
      r_dm_data <= '0;
      r_ready   <= 1'b0;
      r_pc_load <= 1'b0;
      r_sp_load <= 1'b0;
      r_rst_n   <= 1'b0;
      r_clk_en  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_pc      <= w_pc_nxt;
      r_sp      <= w_sp_nxt;
      r_cycle   <= w_cycle_nxt;
      r_im_we   <= w_im_we_nxt;
      r_im_addr <= w_im_addr_nxt;
      r_im_data <= w_im_data_nxt;
      r_dm_we   <= w_dm_we_nxt;
      r_dm_addr <= w_dm_addr_nxt;
      r_dm_data <= w_dm_data_nxt;
      r_ready   <= w_ready_nxt;
      r_pc_load <= w_pc_load_nxt;
      r_sp_load <= w_sp_load_nxt;
      r_rst_n   <= w_rst_n_nxt;
      r_clk_en  <= w_clk_en_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign in_ready_o   = r_ready;
  assign im_we_o      = r_im_we;
  assign im_addr_o    = r_im_addr;
  assign im_data_o    = r_im_data;
  assign dm_we_o      = r_dm_we;
  assign dm_addr_o    = r_dm_addr;
  assign dm_data_o    = r_dm_data;
  assign pc_init_o    = r_pc;
  assign pc_load_o    = r_pc_load;
  assign sp_init_o    = r_sp;
  assign sp_load_o    = r_sp_load;
  assign cpu_rst_n_o  = r_rst_n;
  assign cpu_clk_en_o = r_clk_en;
  assign cycle_o      = r_cycle;
  assign done_o       = r_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: image streams with random stalls,
// checked against an image-level model of expected writes, pulses and run length.
module tb_boot_sequencer;

  localparam int unsigned IMEM = 16;
  localparam int unsigned DMEM = 16;
  localparam int unsigned RUNC = 5;

  logic        clk, rst_n, start, in_valid;
  logic [31:0] in_data;
  logic        in_ready_o, im_we_o, dm_we_o, pc_load_o, sp_load_o;
  logic        cpu_rst_n_o, cpu_clk_en_o, done_o, err_o;
  logic [31:0] im_addr_o, im_data_o, dm_addr_o, dm_data_o;
  logic [31:0] pc_init_o, sp_init_o, cycle_o;

  int total = 0;
  int bad = 0;
  int mon_im = 0, mon_dm = 0, mon_pc = 0, mon_sp = 0;

  // Image under test
  logic [31:0] img_pc, img_sp;
  int unsigned img_icnt, img_dcnt;
  logic [31:0] img_i [IMEM];
  logic [31:0] img_d [DMEM];

  boot_sequencer #(.IMEM_WORDS(IMEM), .DMEM_WORDS(DMEM), .RUN_CYCLES(RUNC)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready_o), .im_we_o(im_we_o), .im_addr_o(im_addr_o), .im_data_o(im_data_o),
    .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_data_o(dm_data_o),
    .pc_init_o(pc_init_o), .pc_load_o(pc_load_o), .sp_init_o(sp_init_o), .sp_load_o(sp_load_o),
    .cpu_rst_n_o(cpu_rst_n_o), .cpu_clk_en_o(cpu_clk_en_o), .cycle_o(cycle_o),
    .done_o(done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe/pulse counters, used to catch duplicate or missing writes
  always @(negedge clk) begin
    if (im_we_o)   mon_im <= mon_im + 1;
    if (dm_we_o)   mon_dm <= mon_dm + 1;
    if (pc_load_o) mon_pc <= mon_pc + 1;
    if (sp_load_o) mon_sp <= mon_sp + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ctl"}, 32'({in_ready_o, im_we_o, dm_we_o, pc_load_o, sp_load_o,
                            cpu_rst_n_o, cpu_clk_en_o, done_o, err_o}), 32'd0);
    chk({tag, "_addr"}, im_addr_o | dm_addr_o, 32'd0);
    chk({tag, "_data"}, im_data_o | dm_data_o, 32'd0);
    chk({tag, "_init"}, pc_init_o | sp_init_o, 32'd0);
    chk({tag, "_cycle"}, cycle_o, 32'd0);
  endtask

  // Present one word with an optional random stall first; returns at the negedge after transfer
  task automatic send_word(input logic [31:0] w, input int unsigned maxgap);
    int unsigned gap;
    bit ok;
    gap = (maxgap == 0) ? 0 : $urandom_range(maxgap, 0);
    for (int g = 0; g < int'(gap); g++) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      start    = 1'($urandom % 2);
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      if (in_ready_o) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic begin_load(input bit from_halt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ready", 32'(in_ready_o), 32'd1);
    if (from_halt) begin
      chk("restart_rst_n", 32'(cpu_rst_n_o), 32'd0);
      chk("restart_cycle", cycle_o, 32'd0);
      chk("restart_done", 32'(done_o), 32'd0);
    end
  endtask

  // Streams the current image (in I_PC on entry) and checks every write one cycle after its edge
  task automatic load_image(input int unsigned maxgap);
    send_word(img_pc, maxgap);
    send_word(32'(img_icnt), maxgap);
    for (int i = 0; i < int'(img_icnt); i++) begin
      send_word(img_i[i], maxgap);
      chk("im_we", 32'(im_we_o), 32'd1);
      chk("im_addr", im_addr_o, 32'(i));
      chk("im_data", im_data_o, img_i[i]);
    end
    send_word(img_sp, maxgap);
    send_word(32'(img_dcnt), maxgap);
    for (int i = 0; i < int'(img_dcnt); i++) begin
      send_word(img_d[i], maxgap);
      chk("dm_we", 32'(dm_we_o), 32'd1);
      chk("dm_addr", dm_addr_o, 32'(4 * i));
      chk("dm_data", dm_data_o, img_d[i]);
    end
    chk("rel_pc_load", 32'(pc_load_o), 32'd1);
    chk("rel_sp_load", 32'(sp_load_o), 32'd1);
    chk("rel_pc_init", pc_init_o, img_pc);
    chk("rel_sp_init", sp_init_o, img_sp);
    chk("rel_rst_n", 32'(cpu_rst_n_o), 32'd0);
  endtask

  // From RELEASE: expect exactly RUNC enabled cycles, then HALT with the core still out of reset
  task automatic run_check();
    int unsigned en;
    bit hit;
    en = 0;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk("run_rst_n", 32'(cpu_rst_n_o), 32'd1);
        chk("run_pulse_end", 32'({pc_load_o, sp_load_o}), 32'd0);
      end
      if (cpu_clk_en_o) begin
        en++;
        chk("run_cycle", cycle_o, 32'(en - 1));
      end
      if (done_o) hit = 1'b1;
    end
    chk("halt_seen", 32'(hit), 32'd1);
    chk("en_cycles", 32'(en), 32'(RUNC));
    chk("halt_cycle", cycle_o, 32'(RUNC));
    chk("halt_clk_en", 32'(cpu_clk_en_o), 32'd0);
    chk("halt_rst_n", 32'(cpu_rst_n_o), 32'd1);
    repeat (3) @(negedge clk);
    chk("halt_hold", cycle_o, 32'(RUNC));
  endtask

  task automatic boot(input bit from_halt, input int unsigned maxgap);
    int s_im, s_dm, s_pc, s_sp;
    s_im = mon_im; s_dm = mon_dm; s_pc = mon_pc; s_sp = mon_sp;
    begin_load(from_halt);
    load_image(maxgap);
    run_check();
    chk("im_strobes", 32'(mon_im - s_im), 32'(img_icnt));
    chk("dm_strobes", 32'(mon_dm - s_dm), 32'(img_dcnt));
    chk("pc_pulses", 32'(mon_pc - s_pc), 32'd1);
    chk("sp_pulses", 32'(mon_sp - s_sp), 32'd1);
  endtask

  task automatic rand_image();
    img_pc = $urandom;
    img_sp = $urandom;
    img_icnt = $urandom_range(IMEM, 0);
    img_dcnt = $urandom_range(DMEM, 0);
    for (int i = 0; i < int'(IMEM); i++) img_i[i] = $urandom;
    for (int i = 0; i < int'(DMEM); i++) img_d[i] = $urandom;
  endtask

  initial begin
    int s_im, s_dm;
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #1 rst_n = 1'b0;
    #2 check_outputs_zero("reset_async");
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready_o), 32'd0);

    // Basic boot
    img_pc = 32'h0; img_icnt = 2; img_i[0] = 32'h20080005; img_i[1] = 32'h01084020;
    img_sp = 32'h400; img_dcnt = 1; img_d[0] = 32'h11223344;
    boot(1'b0, 0);

    // Zero counts: RELEASE right after the fourth accepted word
    img_pc = 32'h100; img_icnt = 0; img_sp = 32'h200; img_dcnt = 0;
    boot(1'b1, 0);

    // Stalls during the data body
    img_pc = 32'h40; img_icnt = 0; img_sp = 32'h800; img_dcnt = 3;
    img_d[0] = 32'hA5A5_0001; img_d[1] = 32'h5A5A_0002; img_d[2] = 32'hDEAD_BEEF;
    boot(1'b1, 3);

    for (int r = 0; r < 4; r++) begin
      rand_image();
      boot(1'b1, 2);
    end

    // Async reset during I_BODY after one of three words
    img_pc = 32'hCAFE_0000; img_icnt = 3;
    begin_load(1'b1);
    send_word(img_pc, 0);
    send_word(32'd3, 0);
    send_word(32'h1234_5678, 0);
    chk("partial_we", 32'(im_we_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle", 32'(in_ready_o), 32'd0);
    img_pc = 32'h0000_0200; img_icnt = 3;
    img_i[0] = 32'h1111_0000; img_i[1] = 32'h2222_0001; img_i[2] = 32'h3333_0002;
    img_sp = 32'h0000_0FFC; img_dcnt = 2; img_d[0] = 32'h0; img_d[1] = 32'hFFFF_FFFF;
    boot(1'b0, 1);

    // Overflow of the instruction count
    begin_load(1'b1);
    send_word(32'h0, 0);
    send_word(32'(IMEM + 1), 0);
    chk("ovf_err", 32'(err_o), 32'd1);
    chk("ovf_ready", 32'(in_ready_o), 32'd0);
    chk("ovf_rst_n", 32'(cpu_rst_n_o), 32'd0);
    chk("ovf_clk_en", 32'(cpu_clk_en_o), 32'd0);
    s_im = mon_im; s_dm = mon_dm;
    start = 1'b1; in_valid = 1'b1; in_data = 32'h5;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("err_sticky", 32'({err_o, in_ready_o, cpu_rst_n_o}), 32'b100);
    end
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("err_no_writes", 32'((mon_im - s_im) + (mon_dm - s_dm)), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("err_cleared", 32'(err_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
